shift_register_sipo: RTL and testbench
======================================

# shift_register_sipo

Serial-in, parallel-out receiver that reassembles MSB-first serial words into `WIDTH`-bit parallel words. It is the receive-side counterpart of the team's 4-bit PISO transmitter. Bits are qualified by a strobe and framed by a start-of-frame marker. Completed words are presented on a valid/ready output port, backed by a one-word holding register and a sticky overrun flag.

## Interface
Parameters:
- `WIDTH`, default 4, number of data bits per word (legal range 2..32).

Ports:
- `clk`, input, 1, rising-edge clock. This is the only clock.
- `reset`, input, 1. Reset is synchronous and active-high.
- `serial_in`, input, 1, serial data bit, MSB first.
- `serial_en`, input, 1, qualifies `serial_in` for one cycle.
- `sof`, input, 1, start of frame. Meaningful only when `serial_en`=1. Marks the current bit as the word's MSB.
- `parallel_out`, output, `WIDTH`, last completed word.
- `out_valid`, output, 1, `parallel_out` holds an unconsumed word.
- `out_ready`, input, 1, downstream accepts the word when `out_valid`=1 and `out_ready`=1.
- `overrun`, output, 1, sticky flag: a completed word was dropped.
- `clear_overrun`, input, 1, clears `overrun`.
- `parity_err`, output, 1, one-cycle pulse on a parity mismatch. Tied 0 when parity is compiled out.

## Operation
FSM states:
- **IDLE**
  - A bit with `serial_en` and `sof` both high is shifted in, the bit counter is set to 1, and the FSM moves to SHIFT.
  - A bit with `serial_en`=1 and `sof`=0 is ignored.
- **SHIFT**
  - Each `serial_en` bit is shifted into `shift_reg` from the LSB side (`shift_reg <= {shift_reg[WIDTH-2:0], serial_in}`), and the counter increments.
  - When the bit that brings the counter to `WIDTH` is taken, the word is complete. The FSM goes to PARITY if `PARITY_CHECK_EN` is defined, otherwise it commits and returns to IDLE.
- **PARITY** (only with `PARITY_CHECK_EN`)
  - The next `serial_en` bit is the parity bit.
  - Its check result is described under Configuration.
  - The FSM then returns to IDLE.

Commit:
- Commit copies the completed word into `parallel_out` and sets `out_valid`.
- If `out_valid`=1 and `out_ready`=0 in the commit cycle, the new word is dropped, `parallel_out` is unchanged, and `overrun` is set.
- If the commit cycle also has `out_valid`=1 and `out_ready`=1, the old word is consumed, the new word is loaded, `out_valid` stays 1, and there is no overrun.

Other behaviour:
- Handshake: when `out_valid`=1, `out_ready`=1 and there is no commit, `out_valid` is cleared the next cycle. `parallel_out` keeps its value.
- `sof` with `serial_en` in SHIFT or PARITY discards the partial word. That bit becomes the MSB of a new word and the counter is set to 1. No flag is raised.
- `serial_en`=0 cycles are stalls. State, counter and `shift_reg` hold indefinitely.
- `clear_overrun` and a new overrun in the same cycle leave `overrun`=1, because set wins.
- Reception continues while `out_valid` is high. The holding register decouples the shift path from the output port.

## Timing
Reset values:
- Synchronous `reset` puts the FSM in IDLE and sets the counter, `shift_reg` and `parallel_out` to 0.
- `out_valid`, `overrun` and `parity_err` reset to 0.
- A reset mid-word discards the partial word.

Latency (all outputs are registered):
- Without parity: the last data bit is strobed in cycle N, and `out_valid` and `parallel_out` update at the N+1 edge.
- With parity: the parity bit is strobed in cycle N, and `out_valid` and `parallel_out` update at N+1.

Throughput and flags:
- Back-to-back words are supported: `sof` may be asserted in the cycle immediately after the last bit, with no dead cycle.
- `overrun` rises in the cycle after the dropping commit.
- `parity_err` is high for exactly one cycle, the cycle after the parity bit.

## Configuration
Macro `SIPO_PARITY_CHECK_EN`.

When defined:
- Each frame is `WIDTH` data bits followed by one even-parity bit.
- Even parity means the XOR of the data bits and the parity bit equals 0.
- On a mismatch the word is not committed and `parity_err` pulses for one cycle.
- On a match the word commits normally.

When undefined:
- Each frame is exactly `WIDTH` bits.
- There is no PARITY state, and `parity_err` is constant 0.

## Test plan
- WIDTH=4, macro off, `out_ready`=1. Strobe 1,0,1,1 with `sof` on the first bit. Required: `parallel_out`=4'b1011 and `out_valid`=1 one cycle after the 4th bit, then `out_valid`=0 the cycle after.
- WIDTH=4, `out_ready`=0. Send 4'hA, then 4'h5 back-to-back. Required: `parallel_out` stays 4'hA and `overrun`=1. After a `clear_overrun` pulse, `overrun`=0.
- WIDTH=4. Send 1,1 and then raise `sof` with the bits 0,1,1,0. Required: `parallel_out`=4'b0110. The partial word is discarded and `overrun`=0.
- WIDTH=4, `out_ready`=0 holding 4'h3. Assert `out_ready` exactly in the commit cycle of 4'hC. Required: `parallel_out`=4'hC, `out_valid` remains 1, `overrun`=0.
- Macro on, WIDTH=4. Send data 1,0,1,1 with parity 1, then data 1,0,1,1 with parity 0. Required: the first frame is accepted (4'b1011). The second gives a one-cycle `parity_err` pulse, and `out_valid` is not set for it.
- Assert `reset` after 2 bits with `serial_en` held high. Required: all outputs are 0 the next cycle, and non-`sof` bits are ignored until the next `sof`.

Source files
------------

// File: rtl/shift_register_sipo.sv
// shift_register_sipo: MSB-first serial-in, parallel-out receiver with a one-word holding register.
// Latency: parallel_out/out_valid update one edge after the last strobed bit of a frame.
// Backpressure: a word completing while the holder is full and out_ready=0 is dropped and sets sticky overrun.
// Optional even-parity check compiled in with `define SIPO_PARITY_CHECK_EN.
module shift_register_sipo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_en,
  input  logic             sof,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] commit_word;
  logic             take_last;
  logic             commit;
  logic             drop;

  // Shift path view of the register after taking the current bit.
  assign next_word = {shift_reg[WIDTH-2:0], serial_in};

  // The data bit that completes a word; a sof bit always restarts instead.
  assign take_last = serial_en && !sof && (state == SHIFT) && (bit_cnt == LAST);

`ifdef SIPO_PARITY_CHECK_EN
  logic par_bit;
  logic par_fail;
  // In PARITY the data word sits untouched in shift_reg; the strobed bit is the parity bit.
  assign par_bit     = serial_en && !sof && (state == PARITY);
  assign par_fail    = par_bit && (^{shift_reg, serial_in});
  assign commit      = par_bit && !par_fail;
  assign commit_word = shift_reg;
`else
  assign commit      = take_last;
  assign commit_word = next_word;
`endif

  // A completed word is lost only when the holder is full and not being drained this cycle.
  assign drop = commit && out_valid && !out_ready;

  // Frame FSM: sof restarts from any state, non-sof bits only count while a word is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (serial_en) begin
      if (sof) begin
        state     <= SHIFT;
        bit_cnt   <= CW'(1);
        shift_reg <= next_word;
      end else begin
        case (state)
          SHIFT: begin
            shift_reg <= next_word;
            bit_cnt   <= bit_cnt + CW'(1);
            if (take_last) begin
`ifdef SIPO_PARITY_CHECK_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end
`ifdef SIPO_PARITY_CHECK_EN
          PARITY: state <= IDLE;
`endif
          default: ;
        endcase
      end
    end
  end

  // Holding register and valid/ready port; a simultaneous drain makes room for the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
    end else if (commit && !drop) begin
      parallel_out <= commit_word;
      out_valid    <= 1'b1;
    end else if (!commit && out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  // One-cycle pulse following a parity bit that fails the even-parity rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_fail;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_sipo.sv
// Bench for shift_register_sipo: directed scenarios then random traffic against a frame-level model.
module tb_shift_register_sipo;

  localparam int W = 4;
`ifdef SIPO_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_en = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         overrun;
  logic         clear_overrun = 1'b0;
  logic         parity_err;

  int checks = 0;
  int failures = 0;

  // Reference model state: bits gathered since the last sof, and the output port view.
  bit           m_active = 1'b0;
  int           m_bits[$];
  logic [W-1:0] m_out = '0;
  logic         m_vld = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_perr = 1'b0;

  shift_register_sipo #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .serial_en     (serial_en),
    .sof           (sof),
    .parallel_out  (parallel_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic b, input logic s,
                            input logic rdy, input logic clr);
    bit commit = 1'b0;
    bit perr = 1'b0;
    bit drop;
    int wv = 0;
    int par = 0;
    if (r) begin
      m_active = 1'b0;
      m_bits.delete();
      m_out = '0; m_vld = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      return;
    end
    if (en) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(int'(b));
        m_active = 1'b1;
      end else if (m_active) begin
        m_bits.push_back(int'(b));
      end
      if (m_active && m_bits.size() == FRAME) begin
        for (int i = 0; i < W; i++) wv = wv * 2 + m_bits[i];
        for (int i = 0; i < FRAME; i++) par = par ^ m_bits[i];
        commit = PAR ? (par == 0) : 1'b1;
        perr = PAR && (par != 0);
        m_active = 1'b0;
        m_bits.delete();
      end
    end
    drop = commit && m_vld && !rdy;
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (commit && !drop) begin
      m_out = wv[W-1:0];
      m_vld = 1'b1;
    end else if (!commit && m_vld && rdy) begin
      m_vld = 1'b0;
    end
    m_perr = perr;
  endtask

  // One clock: drive away from the edge, advance the model at the edge, compare just after.
  task automatic cycle(input logic r, input logic en, input logic b, input logic s,
                       input logic rdy, input logic clr);
    @(negedge clk);
    reset = r; serial_en = en; serial_in = b; sof = s; out_ready = rdy; clear_overrun = clr;
    @(posedge clk);
    model_step(r, en, b, s, rdy, clr);
    #1;
    check("parallel_out", 32'(parallel_out), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_vld));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("parity_err", 32'(parity_err), 32'(m_perr));
  endtask

  // A whole frame, sof on the MSB; rdy_last applies on the frame's final strobe.
  task automatic send_word(input logic [W-1:0] w, input logic par_flip,
                           input logic rdy_body, input logic rdy_last);
    logic [W-1:0] wc;
    wc = w;
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b0, 1'b1, wc[i], (i == W - 1), (PAR || i != 0) ? rdy_body : rdy_last, 1'b0);
    end
    if (PAR) cycle(1'b0, 1'b1, (^wc) ^ par_flip, 1'b0, rdy_last, 1'b0);
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_out", 32'(parallel_out), 32'h0);
    check("rst_vld", 32'(out_valid), 32'h0);

    // Basic word 1011 with out_ready high, then drained
    send_word(4'b1011, 1'b0, 1'b1, 1'b1);
    check("t1_word", 32'(parallel_out), 32'hB);
    check("t1_vld", 32'(out_valid), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_drained", 32'(out_valid), 32'h0);

    // Overrun: A held, 5 dropped back-to-back, then clear
    send_word(4'hA, 1'b0, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0, 1'b0);
    check("t2_kept", 32'(parallel_out), 32'hA);
    check("t2_ovr", 32'(overrun), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_clr", 32'(overrun), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-word sof discards the partial word
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(4'b0110, 1'b0, 1'b1, 1'b1);
    check("t3_word", 32'(parallel_out), 32'h6);
    check("t3_ovr", 32'(overrun), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Drain in the commit cycle: 3 held, C replaces it with no overrun
    send_word(4'h3, 1'b0, 1'b0, 1'b0);
    send_word(4'hC, 1'b0, 1'b0, 1'b1);
    check("t4_word", 32'(parallel_out), 32'hC);
    check("t4_vld", 32'(out_valid), 32'h1);
    check("t4_ovr", 32'(overrun), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_PARITY_CHECK_EN
    // Good parity accepted, bad parity pulses parity_err and is not committed
    send_word(4'b1011, 1'b0, 1'b1, 1'b1);
    check("t5_good", 32'(parallel_out), 32'hB);
    check("t5_good_vld", 32'(out_valid), 32'h1);
    send_word(4'b1011, 1'b1, 1'b1, 1'b1);
    check("t5_perr", 32'(parity_err), 32'h1);
    check("t5_bad_vld", 32'(out_valid), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_pulse_end", 32'(parity_err), 32'h0);
`endif

    // Reset mid-word with a full holder and serial_en high
    send_word(4'h9, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_out", 32'(parallel_out), 32'h0);
    check("t6_vld", 32'(out_valid), 32'h0);
    check("t6_ovr", 32'(overrun), 32'h0);
    for (int i = 0; i < FRAME + 2; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t6_ignored", 32'(out_valid), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
